// File: rtl/locked_cla_adder_pipe.sv
// locked_cla_adder_pipe: key-locked carry-lookahead adder with a valid/ready
// pipeline of STAGES registers and a serially shifted key register.
// Optional feature macro: LOCKED_CLA_OVF_EN adds a pipelined signed-overflow
// flag on ovf_o, computed from the key-gated sum.
module locked_cla_adder_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned NG     = WIDTH / 4,
  parameter int unsigned KEY_W  = 2 * NG,
  parameter logic [KEY_W-1:0] KEY_POL = (WIDTH == 32) ? KEY_W'(16'hA5C3) : '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         key_load_i,
  input  logic                         key_bit_i,
  input  logic [WIDTH-1:0]             add1_i,
  input  logic [WIDTH-1:0]             add2_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [WIDTH:0]               result_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [$clog2(KEY_W+1)-1:0]   key_cnt_o
`ifdef LOCKED_CLA_OVF_EN
  ,
  output logic                         ovf_o
`endif
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);
`ifdef LOCKED_CLA_OVF_EN
  localparam int unsigned PW = WIDTH + 2;
`else
  localparam int unsigned PW = WIDTH + 1;
`endif

  logic [KEY_W-1:0]  key_q;
  logic [KEY_W-1:0]  eff_c;
  logic [NG:0]       carry_c;
  logic [NG-1:0]     cin_c;
  logic [3:0]        gb_c;
  logic [3:0]        pb_c;
  logic [3:0]        cc_c;
  logic              grp_g_c;
  logic              grp_p_c;
  logic [WIDTH-1:0]  sum_c;
  logic [PW-1:0]     payload_c;
  logic [STAGES-1:0] vld_q;
  logic [PW-1:0]     data_q [STAGES];
  logic [STAGES-1:0] rdy_c;
  logic              in_fire_c;

  // Key gates are transparent where the loaded key matches the polarity mask.
  assign eff_c = key_q ^ KEY_POL;

  // Key shift register, LSB-first, with a saturating shift counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      key_q     <= '0;
      key_cnt_o <= '0;
    end else if (key_load_i) begin
      key_q <= {key_bit_i, key_q[KEY_W-1:1]};
      if (key_cnt_o != CNT_W'(KEY_W)) begin
        key_cnt_o <= key_cnt_o + CNT_W'(1);
      end
    end
  end

  // Group-wise lookahead adder with key-gated group carry-ins and sum LSBs.
  always_comb begin
    carry_c = '0;
    cin_c   = '0;
    gb_c    = '0;
    pb_c    = '0;
    cc_c    = '0;
    grp_g_c = 1'b0;
    grp_p_c = 1'b0;
    sum_c   = '0;
    for (int g = 0; g < int'(NG); g++) begin
      cin_c[g] = carry_c[g] ^ eff_c[g];
      for (int j = 0; j < 4; j++) begin
        gb_c[j] = add1_i[4*g+j] & add2_i[4*g+j];
        pb_c[j] = add1_i[4*g+j] ^ add2_i[4*g+j];
      end
      cc_c[0] = cin_c[g];
      cc_c[1] = gb_c[0] | (pb_c[0] & cin_c[g]);
      cc_c[2] = gb_c[1] | (pb_c[1] & gb_c[0]) | (pb_c[1] & pb_c[0] & cin_c[g]);
      cc_c[3] = gb_c[2] | (pb_c[2] & gb_c[1]) | (pb_c[2] & pb_c[1] & gb_c[0])
              | (pb_c[2] & pb_c[1] & pb_c[0] & cin_c[g]);
      grp_g_c = gb_c[3] | (pb_c[3] & gb_c[2]) | (pb_c[3] & pb_c[2] & gb_c[1])
              | (pb_c[3] & pb_c[2] & pb_c[1] & gb_c[0]);
      grp_p_c = &pb_c;
      carry_c[g+1] = grp_g_c | (grp_p_c & cin_c[g]);
      for (int j = 0; j < 4; j++) begin
        sum_c[4*g+j] = pb_c[j] ^ cc_c[j];
      end
      sum_c[4*g] = sum_c[4*g] ^ eff_c[NG+g];
    end
  end

  // Stage-1 payload: carry out, sum and (optionally) signed overflow.
`ifdef LOCKED_CLA_OVF_EN
  assign payload_c = {(add1_i[WIDTH-1] == add2_i[WIDTH-1]) & (sum_c[WIDTH-1] != add1_i[WIDTH-1]),
                      carry_c[NG], sum_c};
`else
  assign payload_c = {carry_c[NG], sum_c};
`endif

  // A stage may load when it is empty or its downstream neighbour can move.
  always_comb begin
    rdy_c = '0;
    rdy_c[STAGES-1] = ~vld_q[STAGES-1] | out_ready_i;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      rdy_c[i] = ~vld_q[i] | rdy_c[i+1];
    end
  end

  assign in_ready_o = rst_ni & ~key_load_i & rdy_c[0];
  assign in_fire_c  = in_valid_i & in_ready_o;

  // Pipeline registers; bubbles are squeezed out as stages advance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (rdy_c[0]) begin
        vld_q[0] <= in_fire_c;
        if (in_fire_c) begin
          data_q[0] <= payload_c;
        end
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (rdy_c[i]) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end
  end

  assign out_valid_o = vld_q[STAGES-1];
  assign result_o    = data_q[STAGES-1][WIDTH:0];
`ifdef LOCKED_CLA_OVF_EN
  assign ovf_o       = data_q[STAGES-1][WIDTH+1];
`endif

endmodule

// File: tb/tb_locked_cla_adder_pipe.sv
// Bench for locked_cla_adder_pipe (WIDTH=32, STAGES=2): directed table,
// handshake corner sequences and randomized traffic against a nibble model.
module tb_locked_cla_adder_pipe;

  localparam int unsigned W      = 32;
  localparam int unsigned STAGES = 2;
  localparam logic [15:0] KPOL   = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_load = 1'b0;
  logic        key_bit = 1'b0;
  logic [31:0] add1 = '0;
  logic [31:0] add2 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  key_cnt;
`ifdef LOCKED_CLA_OVF_EN
  logic        ovf;
`endif

  locked_cla_adder_pipe #(.WIDTH(W), .STAGES(STAGES), .KEY_POL(KPOL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .key_load_i(key_load), .key_bit_i(key_bit),
    .add1_i(add1), .add2_i(add2), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .result_o(result), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .key_cnt_o(key_cnt)
`ifdef LOCKED_CLA_OVF_EN
    , .ovf_o(ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;
  logic [33:0] exp_q [$];
  logic [32:0] seen_q [$];
  logic [15:0] key_m = '0;
  int          cnt_m = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_res = '0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: nibble-by-nibble addition with key-flipped carries and LSBs.
  function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [15:0] key);
    logic [15:0] e;
    logic [32:0] r;
    int c;
    int s;
    e = key ^ KPOL;
    r = '0;
    c = 0;
    for (int g = 0; g < 8; g++) begin
      s = int'(a[4*g +: 4]) + int'(b[4*g +: 4]) + (c ^ int'(e[g]));
      r[4*g +: 4] = 4'(s) ^ {3'b000, e[8+g]};
      c = s / 16;
    end
    r[32] = (c != 0);
    return {(a[31] == b[31]) && (r[31] != a[31]), r};
  endfunction

  // Scoreboard: observe transfers just before the edge that performs them.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst_n) begin
      exp_q.delete();
      key_m = '0;
      cnt_m = 0;
      prev_stall = 1'b0;
    end else begin
      check("key_cnt", 34'(key_cnt), 34'(cnt_m));
      if (prev_stall) begin
        check("hold_valid", 34'(out_valid), 34'(1));
        check("hold_result", 34'(result), 34'(prev_res));
      end
      if (out_valid && out_ready) begin
        check("out_has_expect", 34'(exp_q.size() != 0), 34'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_result", 34'(result), 34'(e[32:0]));
`ifdef LOCKED_CLA_OVF_EN
          check("sb_ovf", 34'(ovf), 34'(e[33]));
`endif
        end
        seen_q.push_back(result);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(add1, add2, key_m));
        acc_cnt++;
      end
      if (key_load) begin
        key_m = {key_bit, key_m[15:1]};
        if (cnt_m < 16) cnt_m++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_res = result;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [15:0] k);
    for (int i = 0; i < 16; i++) begin
      key_load = 1'b1;
      key_bit = k[i];
      tick();
    end
    key_load = 1'b0;
    key_bit = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    add1 = a;
    add2 = b;
    #1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_accept_timeout", 34'(n < 50), 34'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [32:0] r, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("out_timeout", 34'(lat < 50), 34'(1));
    r = result;
  endtask

  typedef struct {
    logic [15:0] key;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [32:0] r;
    int lat;
    int n;
    logic [32:0] want [4];

    tbl[0] = '{16'hA5C3, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000};
    tbl[1] = '{16'hA5C2, 32'h0000_0005, 32'h0000_0003, 33'h0_0000_0009};
    tbl[2] = '{16'hA5C3, 32'h0000_0005, 32'h0000_0003, 33'h0_0000_0008};
    tbl[3] = '{16'hA7C3, 32'h0000_0005, 32'h0000_0003, 33'h0_0000_0018};
    tbl[4] = '{16'hA5C3, 32'h1234_5678, 32'h9ABC_DEF0, 33'h0_ACF1_3568};
    tbl[5] = '{16'hA5C3, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000};
    tbl[6] = '{16'h0000, 32'h0000_0000, 32'h0000_0000, 33'h0_0110_0110};
    tbl[7] = '{16'hA543, 32'h0000_0000, 32'hFFFF_FFFF, 33'h1_0FFF_FFFF};

    // Reset state
    tick();
    check("rst_out_valid", 34'(out_valid), 34'(0));
    check("rst_result", 34'(result), 34'(0));
    check("rst_key_cnt", 34'(key_cnt), 34'(0));
    check("rst_in_ready", 34'(in_ready), 34'(0));
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 34'(in_ready), 34'(1));

    // Directed table
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load_key(tbl[i].key);
      check("tbl_key_cnt", 34'(key_cnt), 34'(16));
      send(tbl[i].a, tbl[i].b);
      wait_out(r, lat);
      check($sformatf("tbl%0d_result", i), 34'(r), 34'(tbl[i].exp));
      check("tbl_latency", 34'(lat), 34'(STAGES - 1));
      tick();
    end

    // Backpressure: fill, stall, release
    load_key(KPOL);
    seen_q.delete();
    out_ready = 1'b0;
    send(32'd1, 32'd1);
    send(32'd2, 32'd2);
    in_valid = 1'b1;
    add1 = 32'd3;
    add2 = 32'd3;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready_low", 34'(in_ready), 34'(0));
      check("bp_stall_result", 34'(result), 34'(2));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 34'(in_ready), 34'(1));
    tick();
    send(32'd4, 32'd4);
    repeat (6) tick();
    want = '{33'd2, 33'd4, 33'd6, 33'd8};
    check("bp_out_count", 34'(seen_q.size()), 34'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < seen_q.size()) check("bp_order", 34'(seen_q[i]), 34'(want[i]));
    end

    // Key load during traffic
    send(32'd10, 32'd20);
    n = acc_cnt;
    in_valid = 1'b1;
    add1 = 32'd7;
    add2 = 32'd7;
    for (int i = 0; i < 16; i++) begin
      key_load = 1'b1;
      key_bit = KPOL[i];
      #1;
      check("kl_in_ready_low", 34'(in_ready), 34'(0));
      tick();
    end
    key_load = 1'b0;
    check("kl_no_accept", 34'(acc_cnt), 34'(n));
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    // Reset with two results in flight
    out_ready = 1'b0;
    send(32'd1, 32'd2);
    send(32'd3, 32'd4);
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 34'(in_ready), 34'(0));
    tick();
    check("rst_mid_out_valid", 34'(out_valid), 34'(0));
    check("rst_mid_result", 34'(result), 34'(0));
    check("rst_mid_key_cnt", 34'(key_cnt), 34'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_mid_ready_back", 34'(in_ready), 34'(1));
    send(32'd0, 32'd0);
    wait_out(r, lat);
    check("zero_key_result", 34'(r), 34'(33'h0_0110_0110));
    tick();

`ifdef LOCKED_CLA_OVF_EN
    load_key(KPOL);
    send(32'h7FFF_FFFF, 32'h0000_0001);
    wait_out(r, lat);
    check("ovf_flag", 34'(ovf), 34'(1));
    check("ovf_result", 34'(r), 34'(33'h0_8000_0000));
    tick();
`endif

    // Randomized traffic with occasional key shifts
    load_key(KPOL);
    for (int i = 0; i < 600; i++) begin
      key_load  = ($urandom_range(0, 24) == 0);
      key_bit   = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: add1 = 32'hFFFF_FFFF;
        default: add1 = $urandom;
      endcase
      add2 = $urandom;
      tick();
    end
    key_load = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    check("drain_empty", 34'(exp_q.size()), 34'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/locked_cla_adder_pipe.md
# locked_cla_adder_pipe

Parametrised, key-locked carry-lookahead adder with a valid/ready streaming interface, a programmable pipeline depth and a serially loaded key register. It is the next generation of the team's fixed 32-bit XOR/XNOR-locked CLA netlists. It is generalised in width and key size, and adds a per-group key-gate polarity mask and backpressure. It sits between the operand source and the result consumer on the locked-datapath benches, and produces correct sums only when the loaded key equals `KEY_POL`.

## Interface
- `WIDTH`, 32: operand width. Must be a multiple of 4 and at least 8.
- `STAGES`, 2: pipeline register stages (1..4), equal to the input-to-output latency.
- `NG`, `WIDTH/4`: number of 4-bit lookahead groups (derived; do not override).
- `KEY_W`, `2*NG`: key length (derived).
- `KEY_POL`, `{KEY_W{1'b0}}` with `KEY_W'hA5C3` used for WIDTH=32: key-gate polarity mask. Bit=1 marks an XNOR gate, bit=0 an XOR gate. The correct key equals `KEY_POL`.
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `key_load_i`  in  1  key shift enable.
- `key_bit_i`  in  1  serial key bit, LSB first.
- `add1_i`  in  WIDTH  operand A.
- `add2_i`  in  WIDTH  operand B.
- `in_valid_i`  in  1  operands valid.
- `in_ready_o`  out  1  block accepts operands.
- `result_o`  out  WIDTH+1  sum; the MSB is the carry out.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts result.
- `key_cnt_o`  out  $clog2(KEY_W+1)  number of key bits shifted since the last reset, saturating at KEY_W.

## Operation
- **Key register `key_q`:** KEY_W bits.
  - On a cycle with `key_load_i=1`, `key_q <= {key_bit_i, key_q[KEY_W-1:1]}`. After KEY_W shifts, `key_bit_i` of the first shift lands at bit 0.
  - `key_cnt_o` increments per shift and saturates at KEY_W.
  - Further shifts keep rotating bits in; the count stays at KEY_W.
- **Key gates:** effective bit `e[k] = key_q[k] ^ KEY_POL[k] ^ 1'b0`, so the gate is transparent when `key_q[k]==KEY_POL[k]`.
  - Bit g (0..NG-1): the carry-in of group g is XORed with `e[g]`. Group 0's nominal carry-in is 0.
  - Bit NG+g: sum bit 4g is XORed with `e[NG+g]`.
- **Arithmetic:**
  - Per group: generate G and propagate P from bits, then lookahead carries within the group.
  - Across groups: group carries c[g+1] = Gg | Pg & c'[g], where c'[g] is the key-gated carry-in.
  - `result_o[WIDTH]` = c[NG] (the carry out of the last group, taken after its own gated carry-in).
- **Stage 1:** the full key-gated sum is computed combinationally from the operands and `key_q`, then registered at acceptance. The key value at acceptance governs that transfer.
- **Stages 2..STAGES:** pure delay registers with valid bits.
- **Handshake:**
  - Input transfer when `in_valid_i & in_ready_o`. Output transfer when `out_valid_o & out_ready_i`.
  - `in_ready_o = ~key_load_i & (~last_valid | out_ready_i | any empty stage ahead)`. The pipeline compacts bubbles, and each stage advances when its downstream slot is free.
  - While `out_valid_o=1` and `out_ready_i=0`, `result_o` is held stable.
- **Simultaneous events:**
  - `key_load_i` together with `in_valid_i`: the key shifts and no operands are accepted.
  - In-flight results are unaffected by key shifts.
- **Reset (`rst_ni=0` at a clock edge):**
  - All stage valid bits are cleared. `key_q`, `key_cnt_o` and `result_o` are set to 0. `out_valid_o=0` and `in_ready_o=0` during reset.
  - A reset mid-operation discards all in-flight results, with no partial output.

## Timing
- Latency: a transfer accepted at edge N presents `out_valid_o=1` after edge N+STAGES-1, assuming no stalls. STAGES=1 therefore gives the result in the cycle after acceptance.
- Throughput: one operation per cycle with `out_ready_i` tied high.
- Full pipeline with `out_ready_i=0` gives `in_ready_o=0`. If `out_ready_i` rises, a new input is accepted in that same cycle.
- Key: a shift is visible to an input accepted on the next edge.
- The first cycle after reset is released: `in_ready_o=1` if `key_load_i=0`.

## Configuration
- `LOCKED_CLA_OVF_EN`:
  - Defined: adds output `ovf_o` (1 bit), the signed overflow `(a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1])`, computed on the key-gated sum and pipelined alongside `result_o`. It resets to 0.
  - Undefined: the port and its logic are absent.

## Test plan
- **Correct key, WIDTH=32, KEY_POL=16'hA5C3, STAGES=2:** shift 16'hA5C3 LSB-first, then send A=32'hFFFF_FFFF, B=1 → `result_o=33'h1_0000_0000` two edges after acceptance, and `key_cnt_o=16`.
- **Wrong carry key:** key = 16'hA5C2 (bit0 flipped), A=5, B=3 → result 9. Fix the key, then A=5, B=3 → result 8.
- **Wrong sum key:** key = 16'hA5C3 ^ 16'h0200 (bit 9 = group 1 sum), A=5, B=3 → result 33'h18.
- **Backpressure:** correct key; stream 1+1, 2+2, 3+3, 4+4 with `out_ready_i=0` → `in_ready_o` drops after the pipeline is full. Then release → outputs 2, 4, 6, 8 in order, none lost or duplicated, and `result_o` is stable while stalled.
- **Key during traffic:** assert `key_load_i` with `in_valid_i=1` → no acceptance while loading, and the in-flight result computed with the old key exits unchanged.
- **Reset mid-flight:** two operations in flight, then `rst_ni=0` for one edge → `out_valid_o=0`, `result_o=0`, `key_cnt_o=0`, and the next result with the zero key reflects KEY_POL mismatches.
- **With `LOCKED_CLA_OVF_EN`:** A=32'h7FFF_FFFF, B=1 with the correct key → `ovf_o=1`.
